// File: rtl/m_step_counter.sv
// m_step_counter: loadable up/down counter/accumulator with programmable step,
// wrap or saturate mode, cascade carry-out and sticky overflow flag.
module m_step_counter #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      STEP_WIDTH  = 8,
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LD,
    input  logic [WIDTH-1:0]      D,
    input  logic                  EN,
    input  logic                  CI,
    input  logic                  UP,
    input  logic [STEP_WIDTH-1:0] STEP,
    input  logic                  CLR_OVF,
    output logic [WIDTH-1:0]      Q,
    output logic                  CO,
    output logic                  WRAP,
    output logic                  OVF
);

    // One extra bit holds the carry (add) or borrow (subtract).
    localparam int unsigned EXT_W = WIDTH + 1;

    logic [EXT_W-1:0] step_ext;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] diff;
    logic             over;
    logic             under;
    logic             step_en;
    logic             wrap_evt;
    logic [WIDTH-1:0] q_next;

    // Step arithmetic, range detection, clamping and the cascade carry-out.
    always_comb begin
        step_ext = EXT_W'(STEP);
        sum      = {1'b0, Q} + step_ext;
        diff     = {1'b0, Q} - step_ext;
        over     = UP & sum[WIDTH];
        under    = ~UP & diff[WIDTH];
        step_en  = EN & CI & ~LD;
        wrap_evt = step_en & (over | under);
        CO       = wrap_evt & ~RESET;
        q_next   = UP ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
        if (SATURATE && over) begin
            q_next = '1;
        end
        if (SATURATE && under) begin
            q_next = '0;
        end
    end

    // Counter value and the one-cycle wrap pulse; priority reset > load > step > hold.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q    <= RESET_VALUE;
            WRAP <= 1'b0;
        end else if (LD) begin
            Q    <= D;
            WRAP <= 1'b0;
        end else if (step_en) begin
            Q    <= q_next;
            WRAP <= wrap_evt;
        end else begin
            WRAP <= 1'b0;
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OVF <= 1'b0;
        end else if (wrap_evt) begin
            OVF <= 1'b1;
        end else if (CLR_OVF) begin
            OVF <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m_step_counter.sv
// Testbench for m_step_counter: a wrapping and a saturating 8-bit instance
// sharing one stimulus, plus a two-stage cascaded 16-bit counter.
module tb_m_step_counter;

    logic       clk = 1'b0;
    logic       rst, ld, en, ci, up, clr;
    logic [7:0] d;
    logic [3:0] step;

    logic [7:0] qa, qb;
    logic       coa, cob, wrapa, wrapb, ovfa, ovfb;

    logic        c_rst, c_ld, c_en, c_up;
    logic [15:0] c_d;
    logic [7:0]  q_lo, q_hi;
    logic        co_lo, co_hi, wrap_lo, wrap_hi, ovf_lo, ovf_hi;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = wrapping instance, 1 = saturating instance.
    int mq[2];
    bit mw[2];
    bit mo[2];
    int mc;

    always #5 clk = ~clk;

    m_step_counter #(.WIDTH(8), .STEP_WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(8'h10)) dut_a (
        .CLK(clk), .RESET(rst), .LD(ld), .D(d), .EN(en), .CI(ci), .UP(up), .STEP(step),
        .CLR_OVF(clr), .Q(qa), .CO(coa), .WRAP(wrapa), .OVF(ovfa));

    m_step_counter #(.WIDTH(8), .STEP_WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(8'h10)) dut_b (
        .CLK(clk), .RESET(rst), .LD(ld), .D(d), .EN(en), .CI(ci), .UP(up), .STEP(step),
        .CLR_OVF(clr), .Q(qb), .CO(cob), .WRAP(wrapb), .OVF(ovfb));

    m_step_counter #(.WIDTH(8), .STEP_WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(8'h00)) dut_lo (
        .CLK(clk), .RESET(c_rst), .LD(c_ld), .D(c_d[7:0]), .EN(c_en), .CI(1'b1), .UP(c_up),
        .STEP(4'd1), .CLR_OVF(1'b0), .Q(q_lo), .CO(co_lo), .WRAP(wrap_lo), .OVF(ovf_lo));

    m_step_counter #(.WIDTH(8), .STEP_WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(8'h00)) dut_hi (
        .CLK(clk), .RESET(c_rst), .LD(c_ld), .D(c_d[15:8]), .EN(1'b1), .CI(co_lo), .UP(c_up),
        .STEP(4'd1), .CLR_OVF(1'b0), .Q(q_hi), .CO(co_hi), .WRAP(wrap_hi), .OVF(ovf_hi));

    // Expected {Q, WRAP, OVF} of instance k.
    function automatic logic [9:0] exp_v(int k);
        return {8'(mq[k]), mw[k], mo[k]};
    endfunction

    // Expected carry-out of instance k for the inputs currently applied.
    function automatic logic exp_co(int k);
        if (rst || ld || !(en && ci)) return 1'b0;
        if (up) return (mq[k] + int'(step)) > 255;
        return int'(step) > mq[k];
    endfunction

    // Applies the counting rules to every reference counter for one edge.
    function automatic void update_model();
        for (int k = 0; k < 2; k++) begin
            bit ev;
            int t;
            ev = 1'b0;
            if (rst) begin
                mq[k] = 16; mw[k] = 1'b0; mo[k] = 1'b0;
            end else begin
                if (ld) begin
                    mq[k] = int'(d);
                end else if (en && ci) begin
                    t = up ? mq[k] + int'(step) : mq[k] - int'(step);
                    if (t > 255) begin
                        ev = 1'b1; mq[k] = (k == 1) ? 255 : t - 256;
                    end else if (t < 0) begin
                        ev = 1'b1; mq[k] = (k == 1) ? 0 : t + 256;
                    end else begin
                        mq[k] = t;
                    end
                end
                mw[k] = ev;
                if (ev) mo[k] = 1'b1;
                else if (clr) mo[k] = 1'b0;
            end
        end
        if (c_rst) mc = 0;
        else if (c_ld) mc = int'(c_d);
        else if (c_en) mc = c_up ? (mc + 1) % 65536 : (mc + 65535) % 65536;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
        update_model();
    endtask

    task automatic drive(input logic r, input logic l, input logic [7:0] dv, input logic e,
                         input logic c, input logic u, input logic [3:0] s, input logic cl);
        rst = r; ld = l; d = dv; en = e; ci = c; up = u; step = s; clr = cl;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 8'h00, 1, 1, 1, 4'd3, 0);
        checks++;
        if ({coa, cob} !== 2'b00) begin
            errors++; $display("FAIL reset_co: got %b expected 00", {coa, cob});
        end
        advance();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ((k == 0 ? {qa, wrapa, ovfa} : {qb, wrapb, ovfb}) !== {8'h10, 2'b00}) begin
                errors++; $display("FAIL reset_state[%0d]: got %h expected %h", k,
                                   (k == 0 ? {qa, wrapa, ovfa} : {qb, wrapb, ovfb}), {8'h10, 2'b00});
            end
        end
        drive(0, 0, 8'h00, 1, 1, 1, 4'd3, 0);
        advance();
        checks++;
        if (qa !== 8'h13 || qa !== 8'(mq[0])) begin
            errors++; $display("FAIL reset_release: got %h expected 13 (model %h)", qa, 8'(mq[0]));
        end
    endtask

    task automatic test_wrap_up();
        drive(0, 1, 8'hFE, 0, 0, 1, 4'd3, 0);
        advance();
        drive(0, 0, 8'h00, 1, 1, 1, 4'd3, 0);
        checks++;
        if (coa !== 1'b1 || coa !== exp_co(0)) begin
            errors++; $display("FAIL wrap_up_co: got %b expected 1", coa);
        end
        advance();
        checks++;
        if ({qa, wrapa, ovfa} !== {8'h01, 2'b11} || {qa, wrapa, ovfa} !== exp_v(0)) begin
            errors++; $display("FAIL wrap_up_edge: got %h expected %h", {qa, wrapa, ovfa}, {8'h01, 2'b11});
        end
        advance();
        checks++;
        if ({qa, wrapa, ovfa} !== {8'h04, 2'b01} || {qa, wrapa, ovfa} !== exp_v(0)) begin
            errors++; $display("FAIL wrap_up_next: got %h expected %h", {qa, wrapa, ovfa}, {8'h04, 2'b01});
        end
    endtask

    task automatic test_saturate_down();
        drive(0, 1, 8'h02, 0, 0, 0, 4'd5, 0);
        advance();
        drive(0, 0, 8'h00, 1, 1, 0, 4'd5, 0);
        checks++;
        if (cob !== 1'b1) begin
            errors++; $display("FAIL sat_down_co: got %b expected 1", cob);
        end
        for (int i = 0; i < 2; i++) begin
            advance();
            checks++;
            if ({qb, wrapb, ovfb} !== {8'h00, 2'b11} || {qb, wrapb, ovfb} !== exp_v(1)) begin
                errors++; $display("FAIL sat_down_step%0d: got %h expected %h", i, {qb, wrapb, ovfb}, {8'h00, 2'b11});
            end
        end
        drive(0, 0, 8'h00, 0, 1, 0, 4'd5, 1);
        advance();
        checks++;
        if (ovfb !== 1'b0 || ovfa !== mo[0]) begin
            errors++; $display("FAIL sat_clr_ovf: got %b/%b expected 0/%b", ovfb, ovfa, mo[0]);
        end
        drive(0, 0, 8'h00, 1, 1, 0, 4'd5, 1);
        advance();
        checks++;
        if ({qb, wrapb, ovfb} !== {8'h00, 2'b11} || {qa, wrapa, ovfa} !== exp_v(0)) begin
            errors++; $display("FAIL sat_set_wins: got %h/%h expected %h/%h",
                               {qb, wrapb, ovfb}, {qa, wrapa, ovfa}, {8'h00, 2'b11}, exp_v(0));
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 8'hFF, 0, 0, 1, 4'd3, 0);
        advance();
        drive(0, 1, 8'h55, 1, 1, 1, 4'd3, 0);
        checks++;
        if ({coa, cob} !== 2'b00) begin
            errors++; $display("FAIL prio_ld_co: got %b expected 00", {coa, cob});
        end
        advance();
        checks++;
        if ({qa, wrapa} !== {8'h55, 1'b0} || {qb, wrapb} !== {8'h55, 1'b0}) begin
            errors++; $display("FAIL prio_ld: got %h/%h expected 55,0", {qa, wrapa}, {qb, wrapb});
        end
        drive(0, 0, 8'h00, 1, 0, 1, 4'd3, 0);
        advance();
        checks++;
        if (qa !== 8'h55 || {qa, wrapa, ovfa} !== exp_v(0)) begin
            errors++; $display("FAIL prio_ci_hold: got %h expected 55", qa);
        end
        drive(0, 0, 8'h00, 1, 1, 1, 4'd0, 0);
        checks++;
        if ({coa, cob} !== 2'b00) begin
            errors++; $display("FAIL zero_step_co: got %b expected 00", {coa, cob});
        end
        advance();
        checks++;
        if ({qa, wrapa} !== {8'h55, 1'b0} || {qb, wrapb, ovfb} !== exp_v(1)) begin
            errors++; $display("FAIL zero_step_hold: got %h expected 55,0", {qa, wrapa});
        end
    endtask

    task automatic test_cascade();
        c_rst = 0; c_ld = 1; c_d = 16'h00FF; c_en = 0; c_up = 1;
        advance();
        c_ld = 0; c_en = 1; c_up = 1;
        advance();
        checks++;
        if ({q_hi, q_lo} !== 16'h0100 || {q_hi, q_lo} !== 16'(mc)) begin
            errors++; $display("FAIL cascade_up: got %h expected 0100", {q_hi, q_lo});
        end
        c_up = 0;
        advance();
        checks++;
        if ({q_hi, q_lo} !== 16'h00FF || {q_hi, q_lo} !== 16'(mc)) begin
            errors++; $display("FAIL cascade_down: got %h expected 00ff", {q_hi, q_lo});
        end
        c_en = 0;
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 8'hFF, 0, 0, 1, 4'd3, 0);
        advance();
        drive(1, 0, 8'h00, 1, 1, 1, 4'd3, 0);
        advance();
        checks++;
        if ({qa, wrapa, ovfa} !== {8'h10, 2'b00} || {qb, wrapb, ovfb} !== {8'h10, 2'b00}) begin
            errors++; $display("FAIL reset_mid: got %h/%h expected 040", {qa, wrapa, ovfa}, {qb, wrapb, ovfb});
        end
        drive(0, 0, 8'h00, 0, 1, 1, 4'd3, 0);
        advance();
        checks++;
        if ({wrapa, ovfa, wrapb, ovfb} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_after: got %b expected 0000", {wrapa, ovfa, wrapb, ovfb});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] dv;
            dv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00) : 8'($urandom);
            c_rst = ($urandom_range(0, 63) == 0);
            c_ld  = ($urandom_range(0, 15) == 0);
            c_d   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {8'($urandom), 8'hFF};
            c_en  = ($urandom_range(0, 3) != 0);
            c_up  = 1'($urandom);
            drive(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0), dv,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 4'($urandom), 1'($urandom_range(0, 7) == 0));
            checks++;
            if ({coa, cob} !== {exp_co(0), exp_co(1)}) begin
                errors++; $display("FAIL rand_co[%0d]: got %b expected %b", i, {coa, cob}, {exp_co(0), exp_co(1)});
            end
            advance();
            checks++;
            if ({qa, wrapa, ovfa, qb, wrapb, ovfb} !== {exp_v(0), exp_v(1)}) begin
                errors++; $display("FAIL rand_state[%0d]: got %h/%h expected %h/%h", i,
                                   {qa, wrapa, ovfa}, {qb, wrapb, ovfb}, exp_v(0), exp_v(1));
            end
            checks++;
            if ({q_hi, q_lo} !== 16'(mc)) begin
                errors++; $display("FAIL rand_cascade[%0d]: got %h expected %h", i, {q_hi, q_lo}, 16'(mc));
            end
        end
    endtask

    initial begin
        mq[0] = 0; mq[1] = 0; mw[0] = 0; mw[1] = 0; mo[0] = 0; mo[1] = 0; mc = 0;
        c_rst = 1; c_ld = 0; c_d = 16'h0000; c_en = 0; c_up = 1;
        test_reset();
        c_rst = 0;
        test_wrap_up();
        test_saturate_down();
        test_priority();
        test_cascade();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_step_counter.md
Name: m_step_counter

Overview:
- Parametrised loadable up/down counter and accumulator.
- Generalises the single-bit half-adder cell into a WIDTH-bit registered adder with a programmable step, direction, wrap or saturate mode, cascade carry and a sticky overflow flag.
- Used for address and length counters in the COUNTERS section, for example blitter source/destination stepping.
- Stages cascade by feeding CO of one stage into CI of the next.

Parameters:
- WIDTH, 16, counter width in bits (≥2).
- STEP_WIDTH, 8, step operand width (1..WIDTH); zero-extended to WIDTH.
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at all-ones (up) or zero (down).
- RESET_VALUE, 0, value loaded into Q on reset.

Ports:
- CLK input 1 system clock; all state changes on the rising edge.
- RESET input 1 synchronous, active-high reset.
- LD input 1 load D into Q.
- D input WIDTH load value.
- EN input 1 count enable.
- CI input 1 cascade carry-in; a step occurs only when EN & CI.
- UP input 1 1 = add STEP, 0 = subtract STEP.
- STEP input STEP_WIDTH step magnitude.
- CLR_OVF input 1 clear the sticky overflow flag.
- Q output WIDTH counter value (registered).
- CO output 1 combinational cascade carry/borrow-out.
- WRAP output 1 registered one-cycle pulse: the previous cycle's step overflowed or underflowed.
- OVF output 1 sticky overflow flag (registered).

Behaviour:
- Reset values (RESET high at the edge): Q = RESET_VALUE, WRAP = 0, OVF = 0. RESET overrides every other input. Mid-operation reset discards the pending step and OVF set.
- Priority at each edge is RESET > LD > step > hold.
- LD=1: Q <= D; WRAP <= 0; OVF unchanged. Any concurrent step is discarded.
- Step condition: S = EN & CI & ~LD.
- Arithmetic uses a WIDTH+1-bit intermediate with STEP zero-extended:
  - UP=1: sum = Q + STEP; overflow when sum[WIDTH] = 1.
  - UP=0: diff = Q - STEP; underflow when STEP > Q.
- SATURATE=0: Q <= low WIDTH bits of sum or diff (modulo wrap).
- SATURATE=1: on overflow Q <= all-ones; on underflow Q <= 0; otherwise as in wrap mode.
- CO = S & (overflow | underflow). It is combinational from Q, STEP, UP, EN, CI and LD, with no latency, so a cascaded stage steps in the same edge. CO is 0 whenever LD = 1 or RESET = 1.
  - Cascaded stages use STEP = 1, UP equal to the lower stage's UP, and EN tied high.
- WRAP <= S & (overflow | underflow). It is high for exactly one cycle after the edge.
- OVF:
  - Set at the same edge on which WRAP is set.
  - Cleared by CLR_OVF.
  - If set and clear occur in the same cycle, set wins.
- STEP = 0 with S = 1: Q unchanged, CO = 0, WRAP = 0.
- S = 0: Q holds and WRAP <= 0.
- Saturated at max with UP=1 and S=1: Q stays all-ones, and CO, WRAP and OVF still assert on every such step.
- Saturated at zero with UP=0: Q stays 0; CO, WRAP and OVF still assert, as above.
- No internal state beyond Q, WRAP and OVF. There is no FSM; the registered datapath is the sequential element.

Test Plan:
- Bench uses WIDTH=8, STEP_WIDTH=4 unless noted.
- Reset: drive RESET=1 with EN=CI=1, UP=1, STEP=3 and RESET_VALUE=0x10 → Q=0x10, WRAP=0, OVF=0. Release RESET → the next edge gives Q=0x13.
- Wrap up: SATURATE=0, LD D=0xFE, then UP=1, STEP=3, EN=CI=1.
  - CO=1 combinationally before the edge.
  - After the edge: Q=0x01, WRAP=1 for one cycle, OVF=1 sticky.
  - Next step: Q=0x04, WRAP=0, OVF=1.
- Saturate down: SATURATE=1, LD D=0x02, UP=0, STEP=5.
  - First step: Q=0x00, CO=1, WRAP=1.
  - Second step: Q=0x00, WRAP=1 again.
  - CLR_OVF alone → OVF=0. CLR_OVF together with an underflowing step → OVF=1 (set wins).
- Priority: LD=1 with D=0x55, EN=CI=1 and Q=0xFF → CO=0, Q=0x55, WRAP=0.
  - Then CI=0 with EN=1 → Q holds at 0x55.
  - STEP=0 with S=1 → Q holds, CO=0.
- Cascade: two 8-bit instances, low stage STEP=1 UP=1, high stage CI=low.CO STEP=1 EN=1, starting at 0x00FF.
  - One edge → 0x0100, both stages updating in the same cycle.
  - Reverse: UP=0 from 0x0100 → 0x00FF.
- Reset mid-operation: while Q=0xFF steps with UP=1, assert RESET on the edge → Q=RESET_VALUE, WRAP=0, OVF=0, with no residual pulse on the following cycle.
